// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks.
//   - PARITY_* : encodings for the PARITY_MODE parameter.
//   - rx_state_e : receive FSM states (3-bit encoding).
//   - calc_div() : oversample divisor, round(clk_freq / (16 * baud)), at least 1.
package uart_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } rx_state_e;

    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        longint unsigned f;
        longint unsigned b;
        longint unsigned q;
        f = clk_freq;
        b = baud;
        q = (f + 8 * b) / (16 * b);
        if (q == 0) begin
            q = 1;
        end
        return 32'(q);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator shared by the UART receive and transmit paths.
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   restart in  synchronous restart: counter returns to 0 on the next clock
//   tick    out one-cycle pulse while the counter sits at DIV-1
module uart_baud_gen #(
    parameter int unsigned DIV = 163
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    assign tick = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: oversamples the rx pin (16x) and recovers start/data/parity/stop
// frames, LSB first.
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   rx           in   serial line, asynchronous to clk, idles high
//   rx_data      out  last received word, held until the next rx_done_tick
//   rx_done_tick out  one-cycle strobe, rx_data and error flags valid
//   parity_err   out  pulses with rx_done_tick on a parity mismatch
//   framing_err  out  pulses with rx_done_tick when any stop bit sampled low
// Build option: define UART_RX_MAJORITY_EN to take each data/parity/stop bit as the
// 2-of-3 majority of samples 7, 8 and 9; otherwise a single sample at 7 is used.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int unsigned SYS_CLK_FREQ = 50000000,
    parameter int unsigned BAUD_RATE    = 19200,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_MODE  = PARITY_ODD
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done_tick,
    output logic                 parity_err,
    output logic                 framing_err
);

    localparam int unsigned DIV = calc_div(SYS_CLK_FREQ, BAUD_RATE);

    localparam logic [3:0] MID_CNT  = 4'd7;
    localparam logic [3:0] LAST_CNT = 4'd15;
`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] DECIDE_CNT = 4'd9;
`else
    localparam logic [3:0] DECIDE_CNT = 4'd7;
`endif
    localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    // Synchroniser, previous sample and "line genuinely seen high" tracking.
    logic       rx_meta_q, rx_meta_d;
    logic       rx_sync_q, rx_sync_d;
    logic       rx_prev_q, rx_prev_d;
    logic [1:0] fill_q, fill_d;
    logic       seen_high_q, seen_high_d;

    rx_state_e                state_q, state_d;
    logic [3:0]               sample_cnt_q, sample_cnt_d;
    logic [2:0]               bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]     shreg_q, shreg_d;
    logic                     bit_val_q, bit_val_d;
    logic                     par_acc_q, par_acc_d;
    logic                     frame_err_q, frame_err_d;
    logic [DATA_BITS-1:0]     rx_data_q, rx_data_d;
    logic                     done_q, done_d;
    logic                     perr_q, perr_d;
    logic                     ferr_q, ferr_d;

    logic tick;
    logic restart;
    logic start_edge;
    logic bit_now;
    logic parity_bad;

    uart_baud_gen #(
        .DIV (DIV)
    ) u_baud_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .tick    (tick)
    );

    always_comb begin
        rx_meta_d = rx;
        rx_sync_d = rx_meta_q;
        rx_prev_d = rx_sync_q;
        fill_d    = {fill_q[0], 1'b1};
        // The preset synchroniser value must not count as a real high level, so only
        // trust rx_sync once the pipeline has been refilled after reset.
        seen_high_d = seen_high_q | (fill_q[1] & rx_sync_q);
    end

    assign start_edge = seen_high_q & rx_prev_q & ~rx_sync_q;

`ifdef UART_RX_MAJORITY_EN
    logic smp7_q, smp7_d;
    logic smp8_q, smp8_d;

    always_comb begin
        smp7_d = smp7_q;
        smp8_d = smp8_q;
        if (tick && (sample_cnt_q == 4'd7)) begin
            smp7_d = rx_sync_q;
        end
        if (tick && (sample_cnt_q == 4'd8)) begin
            smp8_d = rx_sync_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp7_q <= 1'b0;
            smp8_q <= 1'b0;
        end else begin
            smp7_q <= smp7_d;
            smp8_q <= smp8_d;
        end
    end

    // Evaluated on the sample-9 tick, so rx_sync_q is the third sample.
    assign bit_now = (smp7_q & smp8_q) | (smp7_q & rx_sync_q) | (smp8_q & rx_sync_q);
`else
    assign bit_now = rx_sync_q;
`endif

    assign parity_bad = (PARITY_MODE == PARITY_ODD)  ? ~par_acc_q :
                        (PARITY_MODE == PARITY_EVEN) ?  par_acc_q : 1'b0;

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        bit_val_d    = bit_val_q;
        par_acc_d    = par_acc_q;
        frame_err_d  = frame_err_q;
        rx_data_d    = rx_data_q;
        done_d       = 1'b0;
        perr_d       = 1'b0;
        ferr_d       = 1'b0;
        restart      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d      = S_START;
                    sample_cnt_d = '0;
                    bit_cnt_d    = '0;
                    par_acc_d    = 1'b0;
                    frame_err_d  = 1'b0;
                    restart      = 1'b1;
                end
            end

            // Confirm the start bit at mid-cell, then ride out its second half so the
            // 0..15 count of every following bit spans exactly one bit cell.
            S_START: begin
                if (tick) begin
                    sample_cnt_d = sample_cnt_q + 4'd1;
                    if ((sample_cnt_q == MID_CNT) && rx_sync_q) begin
                        state_d = S_IDLE;
                    end else if (sample_cnt_q == LAST_CNT) begin
                        state_d = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (tick) begin
                    sample_cnt_d = sample_cnt_q + 4'd1;
                    if (sample_cnt_q == DECIDE_CNT) begin
                        bit_val_d = bit_now;
                    end
                    if (sample_cnt_q == LAST_CNT) begin
                        shreg_d   = {bit_val_q, shreg_q[DATA_BITS-1:1]};
                        par_acc_d = par_acc_q ^ bit_val_q;
                        if (bit_cnt_q == DATA_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = (PARITY_MODE != PARITY_NONE) ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
            end

            S_PARITY: begin
                if (tick) begin
                    sample_cnt_d = sample_cnt_q + 4'd1;
                    if (sample_cnt_q == DECIDE_CNT) begin
                        bit_val_d = bit_now;
                    end
                    if (sample_cnt_q == LAST_CNT) begin
                        par_acc_d = par_acc_q ^ bit_val_q;
                        state_d   = S_STOP;
                    end
                end
            end

            // The last stop bit finishes at its sample point rather than at the end of
            // the cell: the half bit of slack keeps a back-to-back start edge visible.
            S_STOP: begin
                if (tick) begin
                    sample_cnt_d = sample_cnt_q + 4'd1;
                    if (sample_cnt_q == DECIDE_CNT) begin
                        frame_err_d = frame_err_q | ~bit_now;
                        if (bit_cnt_q == STOP_LAST) begin
                            state_d   = S_IDLE;
                            rx_data_d = shreg_q;
                            done_d    = 1'b1;
                            perr_d    = parity_bad;
                            ferr_d    = frame_err_q | ~bit_now;
                        end
                    end else if (sample_cnt_q == LAST_CNT) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            fill_q       <= '0;
            seen_high_q  <= 1'b0;
            state_q      <= S_IDLE;
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            bit_val_q    <= 1'b0;
            par_acc_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_data_q    <= '0;
            done_q       <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            rx_meta_q    <= rx_meta_d;
            rx_sync_q    <= rx_sync_d;
            rx_prev_q    <= rx_prev_d;
            fill_q       <= fill_d;
            seen_high_q  <= seen_high_d;
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            bit_val_q    <= bit_val_d;
            par_acc_q    <= par_acc_d;
            frame_err_q  <= frame_err_d;
            rx_data_q    <= rx_data_d;
            done_q       <= done_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_done_tick = done_q;
    assign parity_err   = perr_q;
    assign framing_err  = ferr_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer: 8 data bits, odd parity, one stop bit, divisor 4
// (64 clocks per bit). A monitor logs every strobe; each frame's log is compared
// against expectations derived from the bits that were put on the line.
module tb_uart_rx_deframer;

    localparam int unsigned SYS_CLK  = 50_000_000;
    localparam int unsigned BAUD     = 781_250;
    localparam int          BIT_CLKS = 64;
    localparam int          STOP_IDX = 10;  // start + 8 data + parity

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done_tick;
    logic       parity_err;
    logic       framing_err;

    uart_rx_deframer #(
        .SYS_CLK_FREQ (SYS_CLK),
        .BAUD_RATE    (BAUD),
        .DATA_BITS    (8),
        .STOP_BITS    (1),
        .PARITY_MODE  (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_done_tick (rx_done_tick),
        .parity_err   (parity_err),
        .framing_err  (framing_err)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         at;
    } obs_t;

    obs_t obs_q[$];
    int   stray = 0;

    always @(negedge clk) begin
        if (rx_done_tick) begin
            obs_q.push_back('{rx_data, parity_err, framing_err, cyc});
        end else if (parity_err || framing_err) begin
            stray <= stray + 1;
        end
    end

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Odd parity: total number of ones over data and parity bit must be odd.
    function automatic logic model_perr(input logic [7:0] d, input logic p);
        int ones;
        ones = int'(p);
        for (int i = 0; i < 8; i++) begin
            ones += int'(d[i]);
        end
        return (ones % 2) == 0;
    endfunction

    task automatic send_level(input logic b, input int n);
        rx = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // spike_bit >= 0 puts a one-clock high pulse spike_off clocks into that (zero) data bit.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int spike_bit, input int spike_off, output int start);
        start = cyc;
        send_level(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            if (i == spike_bit) begin
                send_level(1'b0, spike_off);
                send_level(1'b1, 1);
                send_level(1'b0, BIT_CLKS - spike_off - 1);
            end else begin
                send_level(d[i], BIT_CLKS);
            end
        end
        send_level(par, BIT_CLKS);
        send_level(stop, BIT_CLKS);
    endtask

    task automatic expect_count(input string name, input int n);
        check({name, "_strobes"}, 32'(obs_q.size()), 32'(n));
    endtask

    task automatic expect_frame(input string name, input int idx, input int start,
                                input logic [7:0] d, input logic pe, input logic fe);
        obs_t o;
        int   rel;
        if (idx < obs_q.size()) begin
            o   = obs_q[idx];
            rel = o.at - start;
            check({name, "_data"}, 32'(o.data), 32'(d));
            check({name, "_perr"}, 32'(o.perr), 32'(pe));
            check({name, "_ferr"}, 32'(o.ferr), 32'(fe));
            // Strobe must land inside the stop-bit cell of its own frame.
            check({name, "_when"}, 32'((rel >= STOP_IDX * BIT_CLKS) &&
                                       (rel < (STOP_IDX + 1) * BIT_CLKS)), 32'(1));
        end
    endtask

    task automatic one_frame(input string name, input logic [7:0] d, input logic par,
                             input logic stop, input logic [7:0] ed, input logic epe,
                             input logic efe);
        int st;
        obs_q.delete();
        send_frame(d, par, stop, -1, 0, st);
        send_level(1'b1, BIT_CLKS);
        expect_count(name, 1);
        expect_frame(name, 0, st, ed, epe, efe);
        check({name, "_hold"}, 32'(rx_data), 32'(ed));
    endtask

    initial begin
        int          st;
        int          st2;
        logic [7:0]  d;
        logic [7:0]  exp_spike;
        vec_t        v;

        // Reset with the line held low: outputs clear, and a line that was never high
        // must not start a frame after release.
        rx    = 1'b0;
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_data", 32'(rx_data), 32'(0));
        check("rst_done", 32'(rx_done_tick), 32'(0));
        check("rst_perr", 32'(parity_err), 32'(0));
        check("rst_ferr", 32'(framing_err), 32'(0));
        rst_n = 1'b1;
        send_level(1'b0, 12 * BIT_CLKS);
        expect_count("low_after_reset", 0);
        send_level(1'b1, 2 * BIT_CLKS);

        // Directed table, expectations worked out by hand from the line bits.
        vecs.push_back('{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0});
        vecs.push_back('{8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0});
        vecs.push_back('{8'h7E, 1'b1, 1'b0, 8'h7E, 1'b0, 1'b1});
        vecs.push_back('{8'h55, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0});
        vecs.push_back('{8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0});
        vecs.push_back('{8'h80, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0});
        vecs.push_back('{8'hC3, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b0});

        // Random rows, expectations from the parity/stop model.
        for (int i = 0; i < 30; i++) begin
            v.data     = 8'($urandom);
            v.par      = 1'($urandom_range(0, 1));
            v.stop     = ($urandom_range(0, 3) != 0);
            v.exp_data = v.data;
            v.exp_perr = model_perr(v.data, v.par);
            v.exp_ferr = ~v.stop;
            vecs.push_back(v);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            one_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].par, vecs[i].stop,
                      vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr);
        end

        // Short low glitch on an idle line: false start, then a clean frame.
        obs_q.delete();
        send_level(1'b0, 12);
        send_level(1'b1, 12 * BIT_CLKS);
        expect_count("glitch", 0);
        one_frame("after_glitch", 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);

        // Reset during data bit 3 of 0xFF, released with the line high.
        obs_q.delete();
        send_level(1'b0, BIT_CLKS);
        send_level(1'b1, 3 * BIT_CLKS + 20);
        rst_n = 1'b0;
        send_level(1'b1, 10);
        check("midrst_data", 32'(rx_data), 32'(0));
        check("midrst_done", 32'(rx_done_tick), 32'(0));
        rst_n = 1'b1;
        send_level(1'b1, 10 * BIT_CLKS);
        expect_count("midrst", 0);
        one_frame("after_rst", 8'h81, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0);

        // Back-to-back frames with a single stop bit.
        obs_q.delete();
        send_frame(8'h12, 1'b1, 1'b1, -1, 0, st);
        send_frame(8'h34, 1'b0, 1'b1, -1, 0, st2);
        send_level(1'b1, BIT_CLKS);
        expect_count("b2b", 2);
        expect_frame("b2b_0", 0, st, 8'h12, 1'b0, 1'b0);
        expect_frame("b2b_1", 1, st2, 8'h34, 1'b0, 1'b0);

        // One-clock spike on bit 2 of 0x00: sample 7 sits 32 clocks into the bit cell,
        // sample 8 sits 36 clocks in.
`ifdef UART_RX_MAJORITY_EN
        exp_spike = 8'h00;
`else
        exp_spike = 8'h04;
`endif
        obs_q.delete();
        send_frame(8'h00, 1'b1, 1'b1, 2, 32, st);
        send_level(1'b1, BIT_CLKS);
        expect_count("spike7", 1);
        expect_frame("spike7", 0, st, exp_spike, model_perr(exp_spike, 1'b1), 1'b0);

        obs_q.delete();
        send_frame(8'h00, 1'b1, 1'b1, 2, 36, st);
        send_level(1'b1, BIT_CLKS);
        d = 8'h00;
        expect_count("spike8", 1);
        expect_frame("spike8", 0, st, d, model_perr(d, 1'b1), 1'b0);

        check("stray_flags", 32'(stray), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
        $finish;
    end

endmodule
